// File: rtl/instr_fetch_ctrl_if.sv
// Bundle of fetch-controller signals: ROM port, decode handshake, redirect,
// run control and debug read. The controller drives through the master modport.
interface instr_fetch_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  // Decode handshake: the word in if_instr/if_pc moves on a cycle where
  // if_valid && if_ready. While if_valid is high and if_ready is low, the
  // producer holds if_instr/if_pc stable. if_ready may depend on nothing here.
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  logic              halt_req;
  logic              run_req;
  logic              halted;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output rom_addr,
    input  rom_data,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    input  redirect_valid,
    input  redirect_pc,
    input  halt_req,
    input  run_req,
    output halted,
    input  dbg_req,
    input  dbg_addr,
    output dbg_ack,
    output dbg_data
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    output redirect_valid,
    output redirect_pc,
    output halt_req,
    output run_req,
    input  halted,
    output dbg_req,
    output dbg_addr,
    input  dbg_ack,
    input  dbg_data
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Program counter, RUN/HALT control and fetch register stage for a
// combinational instruction ROM shared with a debug read port.
module instr_fetch_ctrl #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter bit                START_RUN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_ctrl_if.master  bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              last_dbg_q, last_dbg_d;

  logic fetch_want;
  logic dbg_want;
  logic fetch_gnt;
  logic dbg_gnt;

  // Alternating priority: when both want the ROM, the one not served last wins,
  // which bounds the debug wait to two cycles.
  always_comb begin
    fetch_want = (state_q == ST_RUN) && !bus.redirect_valid &&
                 (!if_valid_q || bus.if_ready);
    dbg_want   = bus.dbg_req && !dbg_ack_q;
    dbg_gnt    = dbg_want && (!fetch_want || !last_dbg_q);
    fetch_gnt  = fetch_want && !dbg_gnt;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (bus.halt_req) state_d = ST_HALT;
      ST_HALT: if (bus.run_req && !bus.halt_req) state_d = ST_RUN;
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_pc;
      if_valid_d = 1'b0;
    end else if (fetch_gnt) begin
      if_instr_d = bus.rom_data;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + ADDR_W'(1);
    end else if (if_valid_q && bus.if_ready) begin
      if_valid_d = 1'b0;
    end
  end

  always_comb begin
    last_dbg_d = last_dbg_q;
    if (dbg_gnt) begin
      last_dbg_d = 1'b1;
    end else if (fetch_gnt) begin
      last_dbg_d = 1'b0;
    end
    dbg_ack_d  = dbg_gnt;
    dbg_data_d = dbg_gnt ? bus.rom_data : dbg_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= START_RUN ? ST_RUN : ST_HALT;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
      dbg_data_q <= '0;
      dbg_ack_q  <= 1'b0;
      last_dbg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      dbg_data_q <= dbg_data_d;
      dbg_ack_q  <= dbg_ack_d;
      last_dbg_q <= last_dbg_d;
    end
  end

  assign bus.rom_addr = dbg_gnt ? bus.dbg_addr : pc_q;
  assign bus.if_valid = if_valid_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.halted   = (state_q == ST_HALT);
  assign bus.dbg_ack  = dbg_ack_q;
  assign bus.dbg_data = dbg_data_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: ROM model, accepted-word scoreboard, a redirect/debug
// vector table and hand-written sequences for stall, halt, debug and reset.
module tb_instr_fetch_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;

  logic clk;
  logic rst;

  instr_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0), .START_RUN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] rom_mem [0:(1<<AW)-1];
  assign bus.rom_data = rom_mem[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit sb_en = 1'b0;
  logic [AW-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0] target;
    logic [AW-1:0] exp_pc0;
    logic [AW-1:0] exp_pc1;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] exp_dbg;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.if_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.halt_req = 1'b0;
    bus.run_req = 1'b0;
    bus.dbg_req = 1'b0;
    bus.dbg_addr = '0;
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [AW-1:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = a;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    bus.if_ready = 1'b0;
  endtask

  // Every word decode accepts must be the next expected address with its ROM word.
  always @(negedge clk) begin
    if (sb_en && !rst && bus.if_valid && bus.if_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_word", 64'(exp_q.size()), 64'd1);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", 64'(bus.if_pc), 64'(e));
        chk("sb_instr", 64'(bus.if_instr), 64'(rom_mem[e]));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit got;
    int acks;

    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 32'hC0DE0000 + 32'(i);
    rom_mem[0] = 32'h40210001;
    rom_mem[1] = 32'hA0000000;

    t = $urandom_range(2, 1021);
    vecs[0] = '{10'h3FF, 10'h3FF, 10'h000, 10'h003, 32'hC0DE0003};
    vecs[1] = '{10'h100, 10'h100, 10'h101, 10'h3FF, 32'hC0DE03FF};
    vecs[2] = '{10'h005, 10'h005, 10'h006, 10'h000, 32'h40210001};
    vecs[3] = '{10'h3FE, 10'h3FE, 10'h3FF, 10'h001, 32'hA0000000};
    vecs[4] = '{AW'(t), AW'(t), AW'(t + 1), AW'(t), 32'hC0DE0000 + 32'(t)};

    // Reset values, then the ADDI / J loop with a redirect back to 0.
    sb_en = 1'b1;
    do_reset();
    exp_q.push_back(10'd0);
    exp_q.push_back(10'd1);
    exp_q.push_back(10'd0);
    chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
    chk("rst_if_instr", 64'(bus.if_instr), 64'd0);
    chk("rst_if_pc", 64'(bus.if_pc), 64'd0);
    chk("rst_dbg_ack", 64'(bus.dbg_ack), 64'd0);
    chk("rst_dbg_data", 64'(bus.dbg_data), 64'd0);
    chk("rst_halted", 64'(bus.halted), 64'd0);
    chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
    tick();
    chk("t1_first_valid", 64'(bus.if_valid), 64'd1);
    chk("t1_first_pc", 64'(bus.if_pc), 64'd0);
    chk("t1_first_instr", 64'(bus.if_instr), 64'h40210001);
    tick();
    chk("t1_jump_pc", 64'(bus.if_pc), 64'd1);
    chk("t1_jump_instr", 64'(bus.if_instr), 64'hA0000000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = '0;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t1_bubble", 64'(bus.if_valid), 64'd0);
    tick();
    chk("t1_refetch_pc0", 64'(bus.if_pc), 64'd0);
    tick();
    chk("t1_refetch_pc1", 64'(bus.if_pc), 64'd1);
    bus.if_ready = 1'b0;
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // Stall three cycles holding pc 5, then release.
    do_reset();
    bus.if_ready = 1'b0;
    redirect_to(10'd5);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_valid", 64'(bus.if_valid), 64'd1);
      chk("t2_stall_pc", 64'(bus.if_pc), 64'd5);
      chk("t2_stall_instr", 64'(bus.if_instr), 64'(rom_mem[5]));
      chk("t2_stall_rom_addr", 64'(bus.rom_addr), 64'd6);
      tick();
    end
    exp_q.push_back(10'd5);
    bus.if_ready = 1'b1;
    tick();
    chk("t2_release_valid", 64'(bus.if_valid), 64'd1);
    chk("t2_release_pc", 64'(bus.if_pc), 64'd6);
    bus.if_ready = 1'b0;
    chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Redirect squashes a stalled word.
    do_reset();
    bus.if_ready = 1'b0;
    redirect_to(10'd7);
    tick();
    chk("t3_stalled_pc", 64'(bus.if_pc), 64'd7);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 10'h100;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t3_squash", 64'(bus.if_valid), 64'd0);
    bus.if_ready = 1'b1;
    tick();
    chk("t3_new_valid", 64'(bus.if_valid), 64'd1);
    chk("t3_new_pc", 64'(bus.if_pc), 64'h100);
    chk("t3_new_instr", 64'(bus.if_instr), 64'(rom_mem[10'h100]));
    bus.if_ready = 1'b0;
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Debug read in the middle of a streaming fetch.
    do_reset();
    for (int i = 0; i < 10; i++) exp_q.push_back(AW'(i));
    tick();
    tick();
    bus.dbg_req = 1'b1;
    bus.dbg_addr = 10'd3;
    #1;
    chk("t4_rom_addr_dbg", 64'(bus.rom_addr), 64'd3);
    got = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bus.dbg_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("t4_dbg_ack_seen", 64'(got), 64'd1);
    chk("t4_dbg_data", 64'(bus.dbg_data), 64'(rom_mem[3]));
    bus.dbg_req = 1'b0;
    acks = 0;
    repeat (3) begin
      tick();
      acks += int'(bus.dbg_ack);
    end
    chk("t4_single_ack", 64'(acks), 64'd0);
    drain(30);

    // Simultaneous halt/run: halt wins, buffered word still delivered.
    do_reset();
    exp_q.push_back(10'd0);
    exp_q.push_back(10'd1);
    tick();
    tick();
    bus.halt_req = 1'b1;
    bus.run_req = 1'b1;
    bus.if_ready = 1'b0;
    tick();
    bus.halt_req = 1'b0;
    bus.run_req = 1'b0;
    chk("t5_halted", 64'(bus.halted), 64'd1);
    chk("t5_buffered_valid", 64'(bus.if_valid), 64'd1);
    chk("t5_buffered_pc", 64'(bus.if_pc), 64'd1);
    chk("t5_held_pc", 64'(bus.rom_addr), 64'd2);
    bus.if_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_fetch", 64'(bus.if_valid), 64'd0);
      chk("t5_stay_halted", 64'(bus.halted), 64'd1);
      tick();
    end
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    chk("t5_running", 64'(bus.halted), 64'd0);
    exp_q.push_back(10'd2);
    exp_q.push_back(10'd3);
    tick();
    chk("t5_resume_valid", 64'(bus.if_valid), 64'd1);
    chk("t5_resume_pc", 64'(bus.if_pc), 64'd2);
    drain(10);

    // Redirect / wrap / debug vector table.
    sb_en = 1'b0;
    foreach (vecs[v]) begin
      do_reset();
      redirect_to(vecs[v].target);
      tick();
      chk("tbl_pc0", 64'(bus.if_pc), 64'(vecs[v].exp_pc0));
      chk("tbl_instr0", 64'(bus.if_instr), 64'(rom_mem[vecs[v].exp_pc0]));
      bus.dbg_req = 1'b1;
      bus.dbg_addr = vecs[v].dbg_addr;
      got = 1'b0;
      for (int k = 0; k < 2; k++) begin
        tick();
        if (bus.dbg_ack) begin
          got = 1'b1;
          break;
        end
      end
      bus.dbg_req = 1'b0;
      chk("tbl_dbg_ack", 64'(got), 64'd1);
      chk("tbl_dbg_data", 64'(bus.dbg_data), 64'(vecs[v].exp_dbg));
      got = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (bus.if_valid) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      chk("tbl_next_valid", 64'(got), 64'd1);
      chk("tbl_pc1", 64'(bus.if_pc), 64'(vecs[v].exp_pc1));
      chk("tbl_instr1", 64'(bus.if_instr), 64'(rom_mem[vecs[v].exp_pc1]));
    end

    // Reset while a debug read is pending: no ack, outputs at reset values.
    do_reset();
    tick();
    tick();
    bus.dbg_req = 1'b1;
    bus.dbg_addr = 10'd7;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t6_no_ack", 64'(bus.dbg_ack), 64'd0);
      chk("t6_dbg_data", 64'(bus.dbg_data), 64'd0);
      chk("t6_if_valid", 64'(bus.if_valid), 64'd0);
      chk("t6_if_pc", 64'(bus.if_pc), 64'd0);
      chk("t6_if_instr", 64'(bus.if_instr), 64'd0);
      chk("t6_halted", 64'(bus.halted), 64'd0);
    end
    bus.dbg_req = 1'b0;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
